serv_pc_seq: RTL and testbench
==============================

SERV_PC_SEQ -- requirements
Module: serv_pc_seq

Interface
REQ-001 SHALL have parameter W, default 1: datapath beat width in bits; legal values 1, 2, 4, 8; a beat cycle covers PC bits [cnt*W+W-1 : cnt*W].
REQ-002 SHALL have parameter RESET_PC, default 32'd0: PC value loaded on reset.
REQ-003 SHALL have parameter WITH_CSR, default 1: when 0, trap input and trap path are absent (i_trap treated as 0).
REQ-004 SHALL have parameter WITH_C, default 0: when 1, compressed (16-bit) instructions are supported and 2-byte-aligned targets are legal.
REQ-005 SHALL have ports: clk in 1 clock; i_rst in 1 synchronous active-high reset.
REQ-006 SHALL have ports: i_start in 1 begin PC update; i_jump, i_jal_or_jalr, i_utype, i_pc_rel, i_trap, i_iscomp in 1 each, control, held stable from start through last beat.
REQ-007 SHALL have ports: i_imm, i_buf, i_csr_pc in W each, per-beat operand slices, LSB-first.
REQ-008 SHALL have ports: o_rd out W, rd result slice; o_bad_pc out W, aligned target slice; o_misalign out 1; o_done out 1; o_busy out 1.
REQ-009 SHALL have ports: o_ibus_adr out 32, fetch address; o_ibus_cyc out 1, fetch request; i_ibus_ack in 1, fetch acknowledge.

Function
REQ-010 SHALL implement states IDLE, SHIFT, FETCH; o_busy=1 in SHIFT and FETCH.
REQ-011 IDLE with i_start=1 SHALL enter SHIFT with beat counter cnt=0 next cycle; i_start outside IDLE SHALL be ignored.
REQ-012 SHIFT SHALL last exactly 32/W cycles, cnt incrementing 0..32/W-1, then enter FETCH.
REQ-013 Each SHIFT beat SHALL rotate o_ibus_adr right by W, inserting new_pc slice at [31:32-W].
REQ-014 Sequential slice SHALL be pc_slice + inc_slice + cy4, where inc = 2 if (WITH_C and i_iscomp) else 4, and inc_slice = bits [cnt*W+W-1:cnt*W] of inc.
REQ-015 Target slice SHALL be a + b + cyo, a = pc_slice if i_pc_rel else 0, b = (i_utype ? (bit index>=12 ? i_imm : 0) : i_buf).
REQ-016 Carries cy4, cyo SHALL be registered per beat, cleared to 0 on the first beat and on reset; carry out of the last beat is discarded (mod 2^32 wrap).
REQ-017 Aligned target SHALL equal target with bit 0 forced to 0; o_bad_pc SHALL output the aligned target slice each beat.
REQ-018 new_pc slice SHALL be: i_trap (WITH_CSR=1) -> i_csr_pc with bits 1:0 forced 0; else i_jump -> aligned target; else sequential.
REQ-019 o_rd SHALL equal (i_utype & aligned target) | (i_jal_or_jalr & sequential) per beat; 0 otherwise.
REQ-020 o_misalign SHALL be set on first FETCH cycle when WITH_C=0, i_jump=1, i_trap=0 and target bit 1 = 1; held until next i_start accepted; PC is still updated.
REQ-021 o_done SHALL pulse high for exactly the first FETCH cycle.
REQ-022 FETCH SHALL hold o_ibus_cyc=1 and o_ibus_adr stable until i_ibus_ack=1 is sampled, then enter IDLE next cycle with o_ibus_cyc=0.
REQ-023 i_ibus_ack outside FETCH SHALL be ignored; ack on the first FETCH cycle SHALL be accepted (single-cycle fetch).
REQ-024 i_start coincident with an accepted ack SHALL be ignored (state not IDLE).

Reset
REQ-025 i_rst=1 SHALL, next cycle, set o_ibus_adr=RESET_PC, carries=0, cnt=0, o_misalign=0, o_done=0, and state FETCH (o_ibus_cyc=1) to fetch the reset vector.
REQ-026 i_rst SHALL override all other inputs, including mid-SHIFT and mid-FETCH; partial PC shifts are discarded.

Verification
REQ-027 W=1, pc 0x100, no jump, i_iscomp=0: start -> after 32 SHIFT cycles o_ibus_adr=0x104, o_done one cycle, cyc until ack.
REQ-028 W=4, WITH_C=1, pc 0x100, i_iscomp=1: -> 0x102 after 8 SHIFT cycles; W=8 wrap pc 0xFFFFFFFC +4 -> 0x00000000.
REQ-029 W=2, JAL: pc 0x1000, i_pc_rel=1, i_buf=0x7FC, i_jump=1, i_jal_or_jalr=1 -> o_ibus_adr=0x17FC, serial o_rd=0x1004.
REQ-030 W=1, AUIPC: pc 0x10, i_utype=1, i_pc_rel=1, i_imm=0x12345000 -> o_rd=0x12345010, PC=0x14.
REQ-031 WITH_CSR=1, i_trap=1, i_csr_pc=0x80000003 -> PC=0x80000000; WITH_C=0 JALR target 0x203 -> PC=0x202, o_misalign=1.
REQ-032 i_rst asserted at SHIFT cnt=5 -> next cycle PC=RESET_PC, o_ibus_cyc=1, o_misalign=0; ack -> IDLE; following start behaves normally.

Source files
------------

// File: rtl/serv_pc_seq.sv
// Bit-serial program counter sequencer: the PC is rotated through W-bit beats while
// the next PC and rd value are formed, then the new PC is fetched over the ibus.
module serv_pc_seq #(
  parameter int          W        = 1,
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter int          WITH_CSR = 1,
  parameter int          WITH_C   = 0
) (
  input  logic         clk,
  input  logic         i_rst,
  input  logic         i_start,
  input  logic         i_jump,
  input  logic         i_jal_or_jalr,
  input  logic         i_utype,
  input  logic         i_pc_rel,
  input  logic         i_trap,
  input  logic         i_iscomp,
  input  logic [W-1:0] i_imm,
  input  logic [W-1:0] i_buf,
  input  logic [W-1:0] i_csr_pc,
  output logic [W-1:0] o_rd,
  output logic [W-1:0] o_bad_pc,
  output logic         o_misalign,
  output logic         o_done,
  output logic         o_busy,
  output logic [31:0]  o_ibus_adr,
  output logic         o_ibus_cyc,
  input  logic         i_ibus_ack
);

  localparam int BEATS = 32 / W;
  localparam int CW    = 5;

  typedef enum logic [1:0] {IDLE, SHIFT, FETCH} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic          cy4, cyo, tgt_bit1;
  logic [31:0]   pc;

  logic          first_beat, last_beat, trap;
  logic [31:0]   bit_base, inc;
  logic          cy4_in, cyo_in;
  logic [W-1:0]  pc_slice, inc_slice, a_slice, b_slice, trap_slice, aligned, new_slice;
  logic [W:0]    seq_sum, tgt_sum;
  logic          bit1_hit, bit1_val;

  assign first_beat = (cnt == '0);
  assign last_beat  = (cnt == CW'(BEATS - 1));
  assign bit_base   = 32'(cnt) * 32'(W);
  assign trap       = (WITH_CSR != 0) && i_trap;

  // The current beat of the PC always sits in the low bits because the register rotates.
  assign pc_slice  = pc[W-1:0];
  assign inc       = ((WITH_C != 0) && i_iscomp) ? 32'd2 : 32'd4;
  assign inc_slice = W'(inc >> bit_base);
  assign cy4_in    = first_beat ? 1'b0 : cy4;
  assign cyo_in    = first_beat ? 1'b0 : cyo;
  assign seq_sum   = {1'b0, pc_slice} + {1'b0, inc_slice} + {{W{1'b0}}, cy4_in};
  assign a_slice   = i_pc_rel ? pc_slice : '0;
  assign tgt_sum   = {1'b0, a_slice} + {1'b0, b_slice} + {{W{1'b0}}, cyo_in};

  always_comb begin
    b_slice    = '0;
    trap_slice = '0;
    for (int j = 0; j < W; j++) begin
      if (i_utype)
        b_slice[j] = (bit_base + 32'(j) >= 32'd12) ? i_imm[j] : 1'b0;
      else
        b_slice[j] = i_buf[j];
      trap_slice[j] = (bit_base + 32'(j) < 32'd2) ? 1'b0 : i_csr_pc[j];
    end
  end

  // Target bit 0 is dropped for the aligned form; bit 1 is remembered for the misalign check.
  always_comb begin
    aligned  = '0;
    bit1_hit = 1'b0;
    bit1_val = 1'b0;
    for (int j = 0; j < W; j++) begin
      aligned[j] = (bit_base + 32'(j) == 32'd0) ? 1'b0 : tgt_sum[j];
      if (bit_base + 32'(j) == 32'd1) begin
        bit1_hit = 1'b1;
        bit1_val = tgt_sum[j];
      end
    end
  end

  assign new_slice = trap ? trap_slice : (i_jump ? aligned : seq_sum[W-1:0]);

  assign o_rd       = ({W{i_utype}} & aligned) | ({W{i_jal_or_jalr}} & seq_sum[W-1:0]);
  assign o_bad_pc   = aligned;
  assign o_ibus_adr = pc;
  assign o_ibus_cyc = (state == FETCH);
  assign o_busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (i_rst) state <= FETCH;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_start)    state_nxt = SHIFT;
      SHIFT:   if (last_beat)  state_nxt = FETCH;
      FETCH:   if (i_ibus_ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      pc         <= RESET_PC;
      cnt        <= '0;
      cy4        <= 1'b0;
      cyo        <= 1'b0;
      tgt_bit1   <= 1'b0;
      o_misalign <= 1'b0;
      o_done     <= 1'b0;
    end else begin
      o_done <= 1'b0;
      if (state == IDLE && i_start) begin
        cnt        <= '0;
        o_misalign <= 1'b0;
      end
      if (state == SHIFT) begin
        pc  <= {new_slice, pc[31:W]};
        cy4 <= seq_sum[W];
        cyo <= tgt_sum[W];
        cnt <= last_beat ? '0 : cnt + CW'(1);
        if (bit1_hit) tgt_bit1 <= bit1_val;
        if (last_beat) begin
          o_done     <= 1'b1;
          o_misalign <= (WITH_C == 0) && i_jump && !trap && tgt_bit1;
        end
      end
    end
  end

endmodule

// File: tb/tb_serv_pc_seq.sv
// Bench for serv_pc_seq: five parameter sets exercised one after another with
// directed table vectors, reset corner cases and random ops against a PC-level model.
module tb_serv_pc_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  localparam int          NCFG   = 5;
  localparam logic [31:0] RST_PC = 32'h0000_0080;

  typedef struct packed {
    logic [31:0] imm;
    logic [31:0] bufv;
    logic [31:0] csr;
    logic        jump, jal, utype, pcrel, trap, comp;
  } op_t;

  typedef struct packed {
    logic [31:0] pc;
    op_t         op;
    logic [31:0] pc_c0, pc_c1, pc_ncsr, rd;
    logic        mis_c0, mis_ncsr;
  } vec_t;

  typedef struct packed {
    logic [31:0] pc, rd, bad;
    logic        mis;
  } res_t;

  vec_t tbl [9];

  function automatic res_t model(input logic [31:0] pc, input op_t op, input int wc, input int ws);
    res_t        r;
    logic [31:0] seq, tgt, aligned;
    logic        trap;
    trap    = (ws != 0) && op.trap;
    seq     = pc + (((wc != 0) && op.comp) ? 32'd2 : 32'd4);
    tgt     = (op.pcrel ? pc : 32'd0) + (op.utype ? (op.imm & 32'hFFFF_F000) : op.bufv);
    aligned = tgt & ~32'd1;
    if (trap)         r.pc = op.csr & ~32'd3;
    else if (op.jump) r.pc = aligned;
    else              r.pc = seq;
    r.rd  = (op.utype ? aligned : 32'd0) | (op.jal ? seq : 32'd0);
    r.bad = aligned;
    r.mis = (wc == 0) && op.jump && !trap && tgt[1];
    return r;
  endfunction

  // flags = {jump, jal, utype, pcrel, trap, comp}
  function automatic vec_t mk(input logic [31:0] pc, immv, bufv, csrv, input logic [5:0] flags,
                              input logic [31:0] p0, p1, pn, rd, input logic m0, mn);
    vec_t v;
    v.pc = pc;
    v.op.imm = immv; v.op.bufv = bufv; v.op.csr = csrv;
    {v.op.jump, v.op.jal, v.op.utype, v.op.pcrel, v.op.trap, v.op.comp} = flags;
    v.pc_c0 = p0; v.pc_c1 = p1; v.pc_ncsr = pn; v.rd = rd;
    v.mis_c0 = m0; v.mis_ncsr = mn;
    return v;
  endfunction

  for (genvar g = 0; g < NCFG; g++) begin : cfg
    localparam int W   = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 4 : (g == 3) ? 8 : 2;
    localparam int WC  = (g == 2 || g == 3) ? 1 : 0;
    localparam int WS  = (g == 4) ? 0 : 1;
    localparam int N   = 32 / W;
    localparam int SEL = (WS == 0) ? 2 : (WC != 0) ? 1 : 0;

    logic         rst = 1'b1, start = 1'b0, ack = 1'b0;
    logic         jump = 1'b0, jal = 1'b0, utype = 1'b0, pcrel = 1'b0, trap = 1'b0, comp = 1'b0;
    logic [W-1:0] imm = '0, bufs = '0, csr = '0;
    logic [W-1:0] rd, bad;
    logic         mis, done, busy, cyc;
    logic [31:0]  adr;
    logic [31:0]  cur_pc;

    serv_pc_seq #(.W(W), .RESET_PC(RST_PC), .WITH_CSR(WS), .WITH_C(WC)) dut (
      .clk(clk), .i_rst(rst), .i_start(start),
      .i_jump(jump), .i_jal_or_jalr(jal), .i_utype(utype), .i_pc_rel(pcrel),
      .i_trap(trap), .i_iscomp(comp),
      .i_imm(imm), .i_buf(bufs), .i_csr_pc(csr),
      .o_rd(rd), .o_bad_pc(bad), .o_misalign(mis), .o_done(done), .o_busy(busy),
      .o_ibus_adr(adr), .o_ibus_cyc(cyc), .i_ibus_ack(ack)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
        miscompares++;
        $display("[TB] FAIL cfg%0d(W=%0d) %s: got %h, expected %h", g, W, name, act, exp);
      end
    endtask

    task automatic applyStimulus(input op_t op, input logic [31:0] exp_pc, exp_rd, exp_bad,
                                 input logic exp_mis, input int ack_delay, input logic start_with_ack);
      logic [31:0] rd_acc = '0;
      logic [31:0] bad_acc = '0;
      @(negedge clk);
      start = 1'b1;
      jump = op.jump; jal = op.jal; utype = op.utype; pcrel = op.pcrel; trap = op.trap; comp = op.comp;
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < N; k++) begin
        if (k > 0) @(negedge clk);
        imm  = op.imm[k*W +: W];
        bufs = op.bufv[k*W +: W];
        csr  = op.csr[k*W +: W];
        #1;
        rd_acc[k*W +: W]  = rd;
        bad_acc[k*W +: W] = bad;
      end
      @(negedge clk);
      checkOutput("done_first_fetch", 32'(done), 32'd1);
      checkOutput("cyc_fetch", 32'(cyc), 32'd1);
      checkOutput("new_pc", adr, exp_pc);
      checkOutput("misalign", 32'(mis), 32'(exp_mis));
      checkOutput("rd", rd_acc, exp_rd);
      checkOutput("bad_pc", bad_acc, exp_bad);
      jump = 1'b0; jal = 1'b0; utype = 1'b0; pcrel = 1'b0; trap = 1'b0; comp = 1'b0;
      for (int d = 0; d < ack_delay; d++) begin
        start = start_with_ack;
        @(negedge clk);
        checkOutput("hold_pc", adr, exp_pc);
        checkOutput("done_pulse", 32'(done), 32'd0);
      end
      ack   = 1'b1;
      start = start_with_ack;
      @(negedge clk);
      ack   = 1'b0;
      start = 1'b0;
      checkOutput("idle_cyc", 32'(cyc), 32'd0);
      checkOutput("idle_busy", 32'(busy), 32'd0);
      checkOutput("mis_hold", 32'(mis), 32'(exp_mis));
      cur_pc = exp_pc;
    endtask

    task automatic setPc(input logic [31:0] v);
      op_t op = '0;
      op.jump = 1'b1;
      op.bufv = v;
      applyStimulus(op, v, 32'd0, v, 1'b0, 0, 1'b0);
    endtask

    task automatic runAll();
      res_t        m;
      op_t         op;
      logic [31:0] exp_pc;
      logic        exp_mis;
      int          k_rst;

      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      checkOutput("reset_pc", adr, RST_PC);
      checkOutput("reset_cyc", 32'(cyc), 32'd1);
      checkOutput("reset_done", 32'(done), 32'd0);
      checkOutput("reset_mis", 32'(mis), 32'd0);
      ack = 1'b1;
      @(negedge clk);
      checkOutput("reset_ack_idle", 32'(busy), 32'd0);
      // Acks while idle must not disturb anything.
      @(negedge clk);
      checkOutput("stray_ack_cyc", 32'(cyc), 32'd0);
      ack = 1'b0;
      cur_pc = RST_PC;

      for (int i = 0; i < 9; i++) begin
        setPc(tbl[i].pc);
        m       = model(tbl[i].pc, tbl[i].op, WC, WS);
        exp_pc  = (SEL == 2) ? tbl[i].pc_ncsr : (SEL == 1) ? tbl[i].pc_c1 : tbl[i].pc_c0;
        exp_mis = (SEL == 2) ? tbl[i].mis_ncsr : (SEL == 1) ? 1'b0 : tbl[i].mis_c0;
        applyStimulus(tbl[i].op, exp_pc, tbl[i].rd, m.bad, exp_mis, i % 3, 1'(i == 4));
      end

      // Leave misalign set, then reset part-way through a shift.
      setPc(32'h300);
      applyStimulus(tbl[6].op, 32'h202, 32'h304, 32'h202, 1'(WC == 0), 0, 1'b0);
      k_rst = (N > 6) ? 5 : N - 2;
      @(negedge clk);
      start = 1'b1;
      pcrel = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < k_rst; k++) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      pcrel = 1'b0;
      checkOutput("midshift_rst_pc", adr, RST_PC);
      checkOutput("midshift_rst_cyc", 32'(cyc), 32'd1);
      checkOutput("midshift_rst_mis", 32'(mis), 32'd0);
      @(negedge clk);
      checkOutput("midshift_rst_hold", adr, RST_PC);
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
      checkOutput("midshift_rst_idle", 32'(busy), 32'd0);
      op = '0;
      applyStimulus(op, RST_PC + 32'd4, 32'd0, 32'd0, 1'b0, 1, 1'b0);

      for (int r = 0; r < 25; r++) begin
        op.imm   = $urandom;
        op.bufv  = $urandom;
        op.csr   = $urandom;
        op.jump  = 1'($urandom_range(0, 1));
        op.jal   = 1'($urandom_range(0, 1));
        op.utype = 1'($urandom_range(0, 1));
        op.pcrel = 1'($urandom_range(0, 1));
        op.trap  = ($urandom_range(0, 5) == 0);
        op.comp  = 1'($urandom_range(0, 1));
        m = model(cur_pc, op, WC, WS);
        applyStimulus(op, m.pc, m.rd, m.bad, m.mis, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end
    endtask
  end

  initial begin
    tbl[0] = mk(32'h100, 0, 0, 0, 6'b000000, 32'h104, 32'h104, 32'h104, 0, 1'b0, 1'b0);
    tbl[1] = mk(32'h100, 0, 0, 0, 6'b000001, 32'h104, 32'h102, 32'h104, 0, 1'b0, 1'b0);
    tbl[2] = mk(32'hFFFF_FFFC, 0, 0, 0, 6'b000000, 0, 0, 0, 0, 1'b0, 1'b0);
    tbl[3] = mk(32'h1000, 0, 32'h7FC, 0, 6'b110100, 32'h17FC, 32'h17FC, 32'h17FC, 32'h1004, 1'b0, 1'b0);
    tbl[4] = mk(32'h10, 32'h1234_5000, 0, 0, 6'b001100, 32'h14, 32'h14, 32'h14, 32'h1234_5010, 1'b0, 1'b0);
    tbl[5] = mk(32'h200, 0, 32'h40, 32'h8000_0003, 6'b100010, 32'h8000_0000, 32'h8000_0000, 32'h40, 0, 1'b0, 1'b0);
    tbl[6] = mk(32'h300, 0, 32'h203, 0, 6'b110000, 32'h202, 32'h202, 32'h202, 32'h304, 1'b1, 1'b1);
    tbl[7] = mk(32'h500, 32'hABCD_E123, 0, 0, 6'b001000, 32'h504, 32'h504, 32'h504, 32'hABCD_E000, 1'b0, 1'b0);
    tbl[8] = mk(32'h1000, 0, 32'hFFFF_FFF0, 0, 6'b100100, 32'hFF0, 32'hFF0, 32'hFF0, 0, 1'b0, 1'b0);
    $display("[TB] starting serv_pc_seq bench");
    cfg[0].runAll();
    cfg[1].runAll();
    cfg[2].runAll();
    cfg[3].runAll();
    cfg[4].runAll();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
